// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter around mux2to1:
// FSM state encoding, default data width and grant decode.
package mux_arb_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // One-hot owner vector; IDLE maps to 2'b00 and the encoding never yields 2'b11.
  function automatic logic [1:0] grant_of(input arb_state_e s);
    return {s == OWN1, s == OWN0};
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Plain 2:1 datapath multiplexer: sel=0 passes data1, sel=1 passes data2.
module mux2to1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? data2 : data1;

endmodule

// File: rtl/mux2to1_arbiter.sv
// Packet-based round-robin arbiter sharing mux2to1 between two valid/ready
// requesters, with a burst limit and a single registered output stage.
module mux2to1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             own0, own1, space, acc, cur_last, other_valid, burst_hit, release_own;
  logic [WIDTH-1:0] mux_out;

  mux2to1 #(.WIDTH(WIDTH)) u_mux (
    .data1 (req0_data),
    .data2 (req1_data),
    .sel   (own1),
    .out   (mux_out)
  );

  assign own0        = (state_q == OWN0);
  assign own1        = (state_q == OWN1);
  assign space       = !out_valid_q || out_ready;
  assign req0_ready  = own0 && space;
  assign req1_ready  = own1 && space;
  assign acc         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign cur_last    = own1 ? req1_last : req0_last;
  assign other_valid = own1 ? req0_valid : req1_valid;
  assign burst_hit   = (beat_cnt_q == BURST_LAST);
  assign release_own = acc && (cur_last || (burst_hit && other_valid));

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) state_d = prio_q ? OWN1 : OWN0;
      else if (req0_valid)          state_d = OWN0;
      else if (req1_valid)          state_d = OWN1;
    end else if (release_own) begin
      prio_d     = own0;
      beat_cnt_d = '0;
      if (other_valid) state_d = own0 ? OWN1 : OWN0;
      else             state_d = IDLE;
    end else if (acc) begin
      // Limit reached with nobody waiting: wrap the count and keep ownership.
      beat_cnt_d = burst_hit ? '0 : beat_cnt_q + CNT_W'(1);
    end

    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_last_d  = cur_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant     = grant_of(state_q);
  assign busy      = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Randomized and directed bench for mux2to1_arbiter against a packet-level
// behavioural model of the round-robin arbitration rules.
module tb_mux2to1_arbiter;

  localparam int W  = 16;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
  logic [W-1:0] req0_data = '0;
  logic         req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
  logic [W-1:0] req1_data = '0;
  logic         out_valid, out_last;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b1;
  logic [1:0]   grant;
  logic         busy;

  always #5 clk = ~clk;

  mux2to1_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .grant      (grant),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner is -1 (nobody), 0 or 1; nb counts beats of the current grant.
  int           m_owner = -1;
  int           m_prio  = 0;
  int           m_nb    = 0;
  logic         m_ov    = 1'b0;
  logic         m_ol    = 1'b0;
  logic [W-1:0] m_od    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_prio = 0; m_nb = 0;
      m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
    end else begin
      logic space, mine, other, lst, accepted;
      space = !m_ov || out_ready;
      if (m_owner == -1) begin
        if (req0_valid && req1_valid) m_owner = m_prio;
        else if (req0_valid)          m_owner = 0;
        else if (req1_valid)          m_owner = 1;
        if (out_ready) m_ov = 1'b0;
      end else begin
        mine     = (m_owner == 1) ? req1_valid : req0_valid;
        other    = (m_owner == 1) ? req0_valid : req1_valid;
        lst      = (m_owner == 1) ? req1_last  : req0_last;
        accepted = mine && space;
        if (accepted) begin
          m_ov = 1'b1;
          m_od = (m_owner == 1) ? req1_data : req0_data;
          m_ol = lst;
          m_nb = m_nb + 1;
          if (lst || (m_nb == MB && other)) begin
            m_prio  = 1 - m_owner;
            m_nb    = 0;
            m_owner = other ? 1 - m_owner : -1;
          end else if (m_nb == MB) begin
            m_nb = 0;
          end
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic sp;
    sp = !m_ov || out_ready;
    chk("req0_ready", 32'(req0_ready), 32'((m_owner == 0) && sp));
    chk("req1_ready", 32'(req1_ready), 32'((m_owner == 1) && sp));
    chk("grant", 32'(grant), (m_owner == 0) ? 32'd1 : (m_owner == 1) ? 32'd2 : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("busy", 32'(busy), 32'((m_owner != -1) || m_ov));
  end

  logic [W-1:0] cap_d[$];
  logic         cap_l[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cap_d.push_back(out_data);
      cap_l.push_back(out_last);
    end
  end

  logic a0, a1;

  // One clock: sample handshakes at the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    req0_valid = 1'b0; req0_last = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_last = 1'b0; req1_data = '0;
    out_ready  = 1'b1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int idx0;
    logic done1;
    logic [W-1:0] exp_b [9];
    logic         exp_l [9];

    // Reset held with both requesters asking.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 16'd4095;  req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 16'd61455; req1_last = 1'b1;
    repeat (3) step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_grant", 32'(grant), 32'd1);

    // Single beat from req0, then prio must point at req1.
    do_reset();
    req0_valid = 1'b1; req0_data = 16'd4095; req0_last = 1'b1;
    step();
    chk("single_grant", 32'(grant), 32'd1);
    chk("single_ov_early", 32'(out_valid), 32'd0);
    step();
    chk("single_ov", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'd4095);
    chk("single_last", 32'(out_last), 32'd1);
    chk("single_idle", 32'(grant), 32'd0);
    req1_valid = 1'b1; req1_data = 16'd61455; req1_last = 1'b1;
    step();
    chk("prio_after_single", 32'(grant), 32'd2);

    // Contention with single-beat packets alternates owners.
    do_reset();
    cap_d.delete(); cap_l.delete();
    req0_valid = 1'b1; req0_data = 16'd4095;  req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 16'd61455; req1_last = 1'b1;
    repeat (10) step();
    idle_in();
    repeat (2) step();
    chk("contend_count", 32'(cap_d.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < cap_d.size(); i++)
      chk("contend_data", 32'(cap_d[i]), (i % 2 == 1) ? 32'd61455 : 32'd4095);

    // Burst limit splits an 8-beat req0 packet around one req1 beat.
    exp_b = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd61455, 16'd5, 16'd6, 16'd7, 16'd8};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    cap_d.delete(); cap_l.delete();
    idx0 = 0; done1 = 1'b0;
    for (int c = 0; c < 60 && !(idx0 == 8 && done1); c++) begin
      req0_valid = (idx0 < 8); req0_data = 16'(idx0 + 1); req0_last = (idx0 == 7);
      req1_valid = !done1;     req1_data = 16'd61455;     req1_last = 1'b1;
      step();
      if (a0) idx0++;
      if (a1) done1 = 1'b1;
    end
    chk("burst_done", 32'(idx0 == 8 && done1), 32'd1);
    idle_in();
    repeat (3) step();
    chk("burst_count", 32'(cap_d.size()), 32'd9);
    for (int i = 0; i < 9 && i < cap_d.size(); i++) begin
      chk("burst_data", 32'(cap_d[i]), 32'(exp_b[i]));
      chk("burst_last", 32'(cap_l[i]), 32'(exp_l[i]));
    end

    // Backpressure in the middle of a 6-beat req0 packet.
    do_reset();
    cap_d.delete(); cap_l.delete();
    idx0 = 0;
    for (int c = 0; c < 60 && idx0 < 6; c++) begin
      req0_valid = 1'b1; req0_data = 16'(idx0 + 1); req0_last = (idx0 == 5);
      out_ready  = !(c >= 4 && c < 7);
      step();
      if (c == 5) chk("bp_ready_low", 32'(req0_ready), 32'd0);
      if (a0) idx0++;
    end
    idle_in();
    repeat (3) step();
    chk("bp_count", 32'(cap_d.size()), 32'd6);
    for (int i = 0; i < 6 && i < cap_d.size(); i++) begin
      chk("bp_data", 32'(cap_d[i]), 32'(i + 1));
      chk("bp_last", 32'(cap_l[i]), 32'(i == 5));
    end

    // Asynchronous reset between clock edges in the middle of a burst.
    do_reset();
    req0_valid = 1'b1; req0_data = 16'd77;    req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 16'd61455; req1_last = 1'b0;
    repeat (4) step();
    chk("pre_arst_ov", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_restart_grant", 32'(grant), 32'd1);

    // Randomized traffic checked every cycle by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_data  = 16'($urandom);
      req0_last  = ($urandom_range(0, 3) == 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_data  = 16'($urandom);
      req1_last  = ($urandom_range(0, 5) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    idle_in();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux2to1_arbiter.md
Name: mux2to1_arbiter

Overview:
Round-robin arbiter that shares the 16-bit 2:1 datapath mux (mux2to1) between two valid/ready requesters and feeds one registered downstream port. It owns the mux select line and grants the mux to one requester per packet, identified by a last flag. A burst limit forces a hand-over to the other requester when that requester is waiting.

Parameters:
WIDTH, 16, data width of both requesters and the output
MAX_BURST, 4, maximum beats per grant before ownership is forced to rotate to a waiting requester (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 beat valid
req0_data  input  WIDTH  requester 0 beat data (mux data1)
req0_last  input  1  requester 0 final beat of packet
req0_ready  output  1  requester 0 beat accepted this cycle when high with valid
req1_valid  input  1  requester 1 beat valid
req1_data  input  WIDTH  requester 1 beat data (mux data2)
req1_last  input  1  requester 1 final beat of packet
req1_ready  output  1  requester 1 beat accepted
out_valid  output  1  registered output beat valid
out_data  output  WIDTH  registered output data
out_last  output  1  registered copy of accepted beat's last
out_ready  input  1  downstream accepts output beat
grant  output  2  one-hot current owner; 2'b00 when idle
busy  output  1  high in any state other than IDLE or while out_valid is set

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prio=0 (req0 preferred), beat_cnt=0, out_valid=0, out_data=0, out_last=0, grant=00, req*_ready=0. Reset mid-transfer drops the held output beat; no recovery.
- FSM states: IDLE, OWN0, OWN1. The mux select is 1 only in OWN1.
- IDLE, one cycle per decision:
  - Only reqN_valid high -> OWN N.
  - Both high -> OWN prio.
  - Neither high -> stay in IDLE.
  - No beat is accepted in IDLE.
- Ready rule: reqN_ready = (state==OWN N) && (!out_valid || out_ready). This is combinational and never depends on reqN_valid.
- Accept: reqN_valid && reqN_ready. On the next edge, out_data <= mux output, out_last <= reqN_last, out_valid <= 1, beat_cnt += 1.
- Output: out_valid clears on out_valid && out_ready with no new accept. It holds data stable while out_ready=0.
- Latency: from IDLE, first req valid to out_valid is 2 cycles. Steady-state throughput is 1 beat/cycle.
- Release in OWN N happens on an accepted beat when:
  - (a) reqN_last=1, or
  - (b) beat_cnt+1 == MAX_BURST and the other requester's valid is high.
- On release:
  - prio <= other requester.
  - beat_cnt <= 0.
  - Next state is OWN other if the other valid is high that cycle; otherwise IDLE.
- No release by rule (b) when the other requester is idle: beat_cnt wraps to 0 and ownership is kept.
- A forced rotation splits a packet. out_last reports only the input last. The downstream tolerates interleaving.
- The owner dropping valid mid-packet keeps ownership; there is no timeout.
- beat_cnt width: $clog2(MAX_BURST)+1. For MAX_BURST=1, every beat releases if the other is waiting.
- grant == {state==OWN1, state==OWN0}. It is never 11.

Decomposition:
- Shared package mux_arb_pkg: state encoding constants (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default WIDTH.
- One sub-module: instantiate the existing mux2to1 for the datapath. The arbiter drives its select; data1=req0_data, data2=req1_data.
- FSM, counter and output register stay in mux2to1_arbiter.

Test Plan:
- Reset: hold rst_n=0 with both valids high -> all outputs 0, grant=00; release -> grant=01 one cycle later (prio=0).
- Single beat: req0 data=4095, last=1, out_ready=1 -> out_data=4095, out_last=1 two cycles after valid; then IDLE, prio=1.
- Contention: both valid, req0=4095, req1=61455, all last=1 -> outputs alternate 4095, 61455, 4095…; grant toggles 01/10 with no IDLE cycles.
- Burst limit: req0 sends an 8-beat packet (1..8, last on 8) while req1 holds 61455 -> output 1,2,3,4,61455,5,6,7,8 with out_last only on 61455 (if req1 last=1) and 8.
- Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data holds, req0_ready=0, no beat lost or duplicated; then resumes.
- Async reset mid-burst: assert rst_n low between edges -> out_valid drops immediately, and the FSM restarts from IDLE with prio=0.
